// File: rtl/alu_dispatch.sv
// Command queue and issue stage in front of the fixed-point ALU: buffers
// inst/a/b triples, issues one per cycle, and sequences matrix loads and busy hold-off.
module alu_dispatch #(
    parameter int unsigned INST_W = 4,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned PTR_W  = 3
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [INST_W-1:0] i_cmd_inst,
    input  logic [DATA_W-1:0] i_cmd_a,
    input  logic [DATA_W-1:0] i_cmd_b,
    input  logic              i_flush,
    output logic              o_alu_valid,
    output logic [INST_W-1:0] o_alu_inst,
    output logic [DATA_W-1:0] o_alu_a,
    output logic [DATA_W-1:0] o_alu_b,
    input  logic              i_alu_busy,
    output logic [PTR_W:0]    o_level,
    output logic [7:0]        o_drop_cnt,
    output logic              o_idle
);

    typedef enum logic [1:0] {StIssue, StMatrix, StWaitHi, StWaitLo} state_e;

    localparam logic [INST_W-1:0] OpLrcw    = INST_W'(5);
    localparam logic [INST_W-1:0] OpMatrix  = INST_W'(9);
    localparam logic [INST_W-1:0] OpIllegal = INST_W'(10);
    localparam logic [3:0]        LastRow   = 4'd7;

    logic [INST_W-1:0] mem_inst [DEPTH];
    logic [DATA_W-1:0] mem_a    [DEPTH];
    logic [DATA_W-1:0] mem_b    [DEPTH];

    logic [PTR_W:0]    wr_ptr_q, rd_ptr_q;
    logic              full, empty, push, pop, issue, drop;
    logic [INST_W-1:0] head_inst, issue_inst;
    logic [DATA_W-1:0] head_a, head_b;

    state_e            state_q, state_d;
    logic [3:0]        row_q, row_d;
    logic [7:0]        drop_cnt_q;
    logic              alu_valid_q;
    logic [INST_W-1:0] alu_inst_q;
    logic [DATA_W-1:0] alu_a_q, alu_b_q;

    // Full when pointers differ only in the wrap bit.
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign push  = i_cmd_valid && !full;

    assign head_inst = mem_inst[rd_ptr_q[PTR_W-1:0]];
    assign head_a    = mem_a[rd_ptr_q[PTR_W-1:0]];
    assign head_b    = mem_b[rd_ptr_q[PTR_W-1:0]];

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_inst[wr_ptr_q[PTR_W-1:0]] <= i_cmd_inst;
            mem_a[wr_ptr_q[PTR_W-1:0]]    <= i_cmd_a;
            mem_b[wr_ptr_q[PTR_W-1:0]]    <= i_cmd_b;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (i_flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // A flush empties the queue this cycle, so nothing is popped alongside it.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        pop        = 1'b0;
        issue      = 1'b0;
        drop       = 1'b0;
        issue_inst = head_inst;
        unique case (state_q)
            StIssue: begin
                if (!empty && !i_flush && !i_alu_busy) begin
                    pop = 1'b1;
                    if (head_inst >= OpIllegal) begin
                        drop = 1'b1;
                    end else begin
                        issue = 1'b1;
                        if (head_inst == OpLrcw) begin
                            state_d = StWaitHi;
                        end else if (head_inst == OpMatrix) begin
                            row_d   = 4'd1;
                            state_d = StMatrix;
                        end
                    end
                end
            end
            StMatrix: begin
                if (!empty && !i_flush) begin
                    pop        = 1'b1;
                    issue      = 1'b1;
                    issue_inst = OpMatrix;
                    if (row_q == LastRow) begin
                        row_d   = 4'd0;
                        state_d = StWaitHi;
                    end else begin
                        row_d = row_q + 4'd1;
                    end
                end
            end
            StWaitHi: if (i_alu_busy)  state_d = StWaitLo;
            StWaitLo: if (!i_alu_busy) state_d = StIssue;
            default:  state_d = StIssue;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= StIssue;
            row_q       <= 4'd0;
            drop_cnt_q  <= 8'd0;
            alu_valid_q <= 1'b0;
            alu_inst_q  <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            alu_valid_q <= issue;
            if (drop && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
            if (issue) begin
                alu_inst_q <= issue_inst;
                alu_a_q    <= head_a;
                alu_b_q    <= head_b;
            end
        end
    end

    assign o_cmd_ready = !full;
    assign o_level     = wr_ptr_q - rd_ptr_q;
    assign o_drop_cnt  = drop_cnt_q;
    assign o_idle      = empty && (state_q == StIssue) && (row_q == 4'd0);
    assign o_alu_valid = alu_valid_q;
    assign o_alu_inst  = alu_inst_q;
    assign o_alu_a     = alu_a_q;
    assign o_alu_b     = alu_b_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// Bench for alu_dispatch: directed scenarios plus random traffic, all checked
// against a queue-based behavioural model of the dispatch rules.
module tb_alu_dispatch;

    logic        i_clk, i_rst, i_cmd_valid, o_cmd_ready, i_flush;
    logic [3:0]  i_cmd_inst, o_alu_inst;
    logic [15:0] i_cmd_a, i_cmd_b, o_alu_a, o_alu_b;
    logic        o_alu_valid, i_alu_busy, o_idle;
    logic [3:0]  o_level;
    logic [7:0]  o_drop_cnt;

    alu_dispatch #(.INST_W(4), .DATA_W(16), .DEPTH(8), .PTR_W(3)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_inst(i_cmd_inst), .i_cmd_a(i_cmd_a), .i_cmd_b(i_cmd_b), .i_flush(i_flush),
        .o_alu_valid(o_alu_valid), .o_alu_inst(o_alu_inst), .o_alu_a(o_alu_a),
        .o_alu_b(o_alu_b), .i_alu_busy(i_alu_busy), .o_level(o_level),
        .o_drop_cnt(o_drop_cnt), .o_idle(o_idle)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [3:0]  inst;
        logic [15:0] a;
        logic [15:0] b;
    } cmd_t;

    localparam int ModeIssue = 0, ModeMatrix = 1, ModeWaitHi = 2, ModeWaitLo = 3;

    int          checks, failures;
    cmd_t        mq[$];
    int          m_mode, m_rows, m_drops;
    logic        m_valid;
    logic [3:0]  m_inst;
    logic [15:0] m_a, m_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_mode = ModeIssue; m_rows = 0; m_drops = 0;
        m_valid = 1'b0; m_inst = '0; m_a = '0; m_b = '0;
    endtask

    // One clock of the dispatch rules, using the inputs currently driven.
    task automatic model_edge();
        int   cur = m_mode;
        bit   can_push = (mq.size() < 8);
        bit   pop = 0;
        bit   iss = 0;
        cmd_t h;
        if (!i_flush && mq.size() != 0) begin
            h = mq[0];
            if (cur == ModeIssue && !i_alu_busy) begin
                pop = 1;
                if (h.inst >= 4'd10) begin
                    if (m_drops < 255) m_drops++;
                end else begin
                    iss = 1;
                    if (h.inst == 4'd5) m_mode = ModeWaitHi;
                    else if (h.inst == 4'd9) begin m_rows = 1; m_mode = ModeMatrix; end
                end
            end else if (cur == ModeMatrix) begin
                pop = 1; iss = 1; h.inst = 4'd9;
                m_rows++;
                if (m_rows == 8) begin m_rows = 0; m_mode = ModeWaitHi; end
            end
        end
        if (cur == ModeWaitHi && i_alu_busy)  m_mode = ModeWaitLo;
        if (cur == ModeWaitLo && !i_alu_busy) m_mode = ModeIssue;
        m_valid = iss;
        if (iss) begin m_inst = h.inst; m_a = h.a; m_b = h.b; end
        if (i_flush) mq.delete();
        else begin
            if (pop) void'(mq.pop_front());
            if (i_cmd_valid && can_push) mq.push_back('{i_cmd_inst, i_cmd_a, i_cmd_b});
        end
    endtask

    task automatic check_all();
        chk("alu_valid", 32'(o_alu_valid), 32'(m_valid));
        chk("alu_inst", 32'(o_alu_inst), 32'(m_inst));
        chk("alu_a", 32'(o_alu_a), 32'(m_a));
        chk("alu_b", 32'(o_alu_b), 32'(m_b));
        chk("level", 32'(o_level), 32'(mq.size()));
        chk("cmd_ready", 32'(o_cmd_ready), 32'(mq.size() < 8));
        chk("drop_cnt", 32'(o_drop_cnt), 32'(m_drops));
        chk("idle", 32'(o_idle), 32'(mq.size() == 0 && m_mode == ModeIssue && m_rows == 0));
    endtask

    task automatic cyc(input logic v, input logic [3:0] inst, input logic [15:0] a,
                       input logic [15:0] b, input logic fl, input logic busy);
        i_cmd_valid = v; i_cmd_inst = inst; i_cmd_a = a; i_cmd_b = b;
        i_flush = fl; i_alu_busy = busy;
        model_edge();
        @(posedge i_clk);
        #1;
        check_all();
    endtask

    task automatic nop(input logic busy);
        cyc(1'b0, 4'd0, 16'd0, 16'd0, 1'b0, busy);
    endtask

    initial begin
        checks = 0; failures = 0;
        i_cmd_valid = 0; i_cmd_inst = 0; i_cmd_a = 0; i_cmd_b = 0;
        i_flush = 0; i_alu_busy = 0; i_rst = 1;
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        check_all();
        chk("reset_ready", 32'(o_cmd_ready), 32'd1);
        chk("reset_idle", 32'(o_idle), 32'd1);
        i_rst = 0;

        // Single ADD: issued two edges after the push.
        cyc(1, 4'd0, 16'h0400, 16'h0800, 0, 0);
        nop(0);
        chk("add_valid", 32'(o_alu_valid), 32'd1);
        chk("add_a", 32'(o_alu_a), 32'h0400);
        chk("add_b", 32'(o_alu_b), 32'h0800);
        nop(0);
        chk("add_after_idle", 32'(o_idle), 32'd1);

        // Back-to-back SUBs.
        for (int i = 1; i <= 3; i++) cyc(1, 4'd1, 16'(i), 16'd0, 0, 0);
        chk("sub_stream", 32'(o_alu_valid), 32'd1);
        nop(0); nop(0);

        // LRCW then ADD; ALU busy for cycles 2..5 after the LRCW issue.
        cyc(1, 4'd5, 16'h0055, 16'h0066, 0, 0);
        cyc(1, 4'd0, 16'h0011, 16'h0022, 0, 0);
        chk("lrcw_issue", 32'(o_alu_inst), 32'd5);
        nop(0);
        repeat (4) nop(1);
        nop(0);
        nop(0);
        chk("post_lrcw_valid", 32'(o_alu_valid), 32'd1);
        chk("post_lrcw_a", 32'(o_alu_a), 32'h0011);
        nop(0);

        // Matrix load with a 2-cycle empty gap after the 4th row.
        cyc(1, 4'd9, 16'h0000, 16'h1000, 0, 0);
        for (int i = 1; i <= 3; i++) cyc(1, (i % 2 == 1) ? 4'd0 : 4'd15, 16'(i), 16'h2000, 0, 0);
        nop(0); nop(1); nop(0);
        for (int i = 4; i <= 7; i++) cyc(1, (i % 2 == 1) ? 4'd0 : 4'd15, 16'(i), 16'h2000, 0, 1);
        nop(0);
        chk("matrix_last_inst", 32'(o_alu_inst), 32'd9);
        chk("matrix_last_a", 32'(o_alu_a), 32'd7);
        chk("matrix_drops", 32'(o_drop_cnt), 32'd0);
        nop(1); nop(0); nop(0);

        // Fill while busy, then flush together with a push.
        for (int i = 0; i < 9; i++) cyc(1, 4'd2, 16'(i), 16'd0, 0, 1);
        chk("full_level", 32'(o_level), 32'd8);
        chk("full_ready", 32'(o_cmd_ready), 32'd0);
        cyc(1, 4'd3, 16'h0abc, 16'd0, 1, 1);
        chk("flush_level", 32'(o_level), 32'd0);
        nop(0); nop(0);

        // Illegal opcode is dropped.
        cyc(1, 4'd12, 16'h0001, 16'h0001, 0, 0);
        nop(0);
        chk("drop_one", 32'(o_drop_cnt), 32'd1);

        // Asynchronous reset in the middle of a matrix load.
        cyc(1, 4'd9, 16'h0100, 16'd0, 0, 0);
        cyc(1, 4'd1, 16'h0101, 16'd0, 0, 0);
        cyc(1, 4'd1, 16'h0102, 16'd0, 0, 0);
        nop(0);
        i_rst = 1;
        model_reset();
        #2;
        check_all();
        chk("async_rst_valid", 32'(o_alu_valid), 32'd0);
        @(posedge i_clk);
        #1;
        i_rst = 0;
        check_all();

        // Drop counter saturation.
        for (int i = 0; i < 260; i++) cyc(1, 4'(10 + (i % 6)), 16'(i), 16'd0, 0, 0);
        nop(0); nop(0);
        chk("drop_saturate", 32'(o_drop_cnt), 32'd255);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 5) == 0) ? (($urandom_range(0, 1) == 0) ? 4'd5 : 4'd9)
                                             : 4'($urandom_range(0, 15));
            cyc($urandom_range(0, 3) != 0, op, 16'($urandom), 16'($urandom),
                $urandom_range(0, 40) == 0, $urandom_range(0, 2) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_dispatch.md
# alu_dispatch

Command queue and issue stage that sits directly upstream of the fixed-point ALU. It buffers incoming instruction/operand triples in a FIFO and issues them to the ALU at up to one per cycle. It honours the ALU busy handshake, including the delayed busy rise after multi-cycle instructions. It sequences the 8-row matrix-load instruction and drops opcodes the ALU does not implement.

## Interface
- INST_W, 4, instruction width
- DATA_W, 16, operand width (Q6.10)
- DEPTH, 8, FIFO entries (power of 2, ≥2)
- PTR_W, 3, log2(DEPTH)

- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset; one clock; reset is asynchronous and active-high
- i_cmd_valid  in  1  upstream command valid
- o_cmd_ready  out  1  FIFO not full; push occurs when i_cmd_valid & o_cmd_ready
- i_cmd_inst  in  INST_W  opcode
- i_cmd_a  in  DATA_W  operand A
- i_cmd_b  in  DATA_W  operand B
- i_flush  in  1  discard all queued entries
- o_alu_valid  out  1  registered issue strobe to ALU i_in_valid
- o_alu_inst  out  INST_W  registered opcode to ALU
- o_alu_a  out  DATA_W  registered operand A
- o_alu_b  out  DATA_W  registered operand B
- i_alu_busy  in  1  ALU o_busy
- o_level  out  PTR_W+1  current FIFO occupancy, 0..DEPTH
- o_drop_cnt  out  8  count of dropped illegal opcodes; saturates at 255
- o_idle  out  1  FIFO empty and FSM in S_ISSUE with row count 0

## Operation
- FIFO: circular buffer, wr/rd pointers PTR_W+1 bits. Full when pointers differ only in MSB. o_cmd_ready = !full, not dependent on same-cycle pop.
- Push and pop in the same cycle are allowed when the FIFO is neither full nor empty. Occupancy is unchanged.
- i_flush resets both pointers and takes priority over a same-cycle push and pop. The FSM, row counter and outputs are unaffected.
- Pop = remove the head entry. Issue = register the head entry onto o_alu_* with o_alu_valid=1 on the next cycle.
- FSM states:
  - S_ISSUE: If the FIFO is non-empty and i_alu_busy=0, pop.
    - Opcode 1010–1111: dropped, not issued; o_drop_cnt+1; stay.
    - Opcode 0101 (LRCW): issue → S_WAIT_HI.
    - Opcode 1001 (matrix): issue, row count ← 1 → S_MATRIX.
    - Otherwise: issue, stay.
  - S_MATRIX: i_alu_busy is ignored. If the FIFO is non-empty, pop and issue with o_alu_inst forced to 4'b1001, keeping a/b from the entry. Any queued opcode, illegal included, is consumed as a row. Row count +1. When the 8th row is issued → S_WAIT_HI, row count ← 0. If the FIFO is empty, o_alu_valid=0 and the state is held.
  - S_WAIT_HI: no pop. → S_WAIT_LO when i_alu_busy=1.
  - S_WAIT_LO: no pop. → S_ISSUE when i_alu_busy=0.
- o_alu_valid=0 in every cycle without an issue. o_alu_inst/a/b hold their last issued values.

## Timing
- Reset values: o_alu_valid=0, o_alu_inst=0, o_alu_a=0, o_alu_b=0, o_drop_cnt=0, o_level=0, o_cmd_ready=1, o_idle=1. FSM=S_ISSUE, row count=0, pointers=0.
- Latency:
  - Push at edge k → entry poppable in cycle k+1.
  - Pop decision in cycle t → o_alu_valid high in cycle t+1.
  - Minimum push-to-ALU latency: 2 cycles.
- Throughput: 1 issue/cycle for opcodes 0000–0100 and 0110–1000, back-to-back with no bubble.
- Busy hold-off: the ALU raises busy one cycle after sampling LRCW or the 8th matrix row. S_WAIT_HI prevents a command being issued into that gap. Minimum gap between an LRCW issue and the next issue is 3 cycles even for cpop=0.
- Reset asserted mid-operation (any state, including S_MATRIX or S_WAIT_*) clears everything immediately. Queued commands are lost.
- A dropped opcode consumes one cycle with no issue.

## Test plan
- Reset, push ADD 0000 a=0x0400 b=0x0800 with busy=0 → one cycle later o_alu_valid=1, inst=0, a=0x0400, b=0x0800; next cycle valid=0, o_idle=1.
- Push 3 back-to-back SUB commands (a=1,2,3) → three consecutive o_alu_valid cycles in order, no bubble.
- Push LRCW 0101, then ADD. Bench drives busy=1 for cycles 2–5 after the LRCW issue → ADD is not issued before busy falls; it issues one cycle after busy=0 is sampled.
- Push 1001 plus 7 entries with opcodes 0000/1111, a=0x0001..0x0007. Insert a 2-cycle empty gap after the 4th row → 8 issues all with inst=1001, a values in order, valid=0 during the gap, o_drop_cnt stays 0, then S_WAIT_HI.
- Hold busy=1 and push 9 commands → o_cmd_ready=0 after the 8th push, o_level=8. Assert i_flush together with a push → o_level=0 next cycle, no issue.
- Push opcode 1100 → no o_alu_valid, o_drop_cnt=1. Assert i_rst in S_MATRIX after 3 rows → all outputs return to reset values asynchronously.
